// File: rtl/simplex8_pkg.sv
// simplex8_pkg
// Shared definitions for the simplex8 run controller: the sequencing state
// type and the default program-memory bus widths.
package simplex8_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // IDLE : halted, waiting for RUN / STEP edge / loader request
  // FETCH: one cycle, PC/instruction latch enabled
  // EXEC : EXEC_CYCLES cycles, commit in the last one
  // LOAD : loader owns the program memory bus
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    LOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/run_controller.sv
// run_controller
// Sequences the simplex8 CPU through FETCH / EXEC, supports free-run and
// single-step, and hands the program memory bus to a loader on request.
//
// Ports
//   CLK, RESET            clock, asynchronous active-low reset
//   RUN                   level, high = free-run
//   STEP                  single-step request (rising edge detected here)
//   HALT_REQ              decoded HALT from control logic
//   LD_REQ/ADDR/WDATA/WE  loader bus
//   LD_GNT                loader owns the memory bus
//   CPU_ADDR/WDATA/WE     CPU datapath memory bus
//   MEM_ADDR/WDATA/WE     program memory bus
//   FETCH_EN, EXEC_EN     PC/latch enable, ALU/register/flag commit enable
//   HALTED                high in IDLE
//   INSTR_COUNT           retired instruction count (wraps)
//   DBG_STATE             current sequencing state
//
// Loader handshake: LD_REQ is a level request. The controller grants only
// from IDLE (an instruction in flight always completes first); LD_GNT is high
// for every LOAD cycle, and the bus returns to the CPU the cycle after LD_REQ
// is seen low. LD_REQ must stay high until the loader has finished.
module run_controller
  import simplex8_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int EXEC_CYCLES = 2           // legal 1..4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic              STEP,
  input  logic              HALT_REQ,
  input  logic              LD_REQ,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_WDATA,
  input  logic              LD_WE,
  output logic              LD_GNT,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  input  logic              CPU_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              FETCH_EN,
  output logic              EXEC_EN,
  output logic              HALTED,
  output logic [15:0]       INSTR_COUNT,
  output state_t            DBG_STATE
);

  localparam logic [1:0] EXEC_CNT_INIT = 2'(EXEC_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_exec_cnt;
  logic [1:0]  w_exec_cnt_nxt;
  logic        r_step_q;
  logic        r_halt_hold;
  logic        w_halt_hold_nxt;
  logic [15:0] r_instr_count;
  logic        w_step_edge;
  logic        w_in_load;
  logic        w_exec_en;

  assign w_step_edge = STEP & ~r_step_q;
  assign w_in_load   = (r_state == LOAD);
  assign w_exec_en   = (r_state == EXEC) && (r_exec_cnt == 2'd0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= IDLE;
      r_exec_cnt    <= 2'd0;
      r_step_q      <= 1'b0;
      r_halt_hold   <= 1'b0;
      r_instr_count <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_exec_cnt  <= w_exec_cnt_nxt;
      r_step_q    <= STEP;
      r_halt_hold <= w_halt_hold_nxt;
      if (w_exec_en) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  // r_halt_hold remembers that the last instruction was a HALT, so a held
  // RUN level does not immediately restart the CPU; a STEP edge (or dropping
  // RUN) releases it.
  always_comb begin
    w_state_nxt     = r_state;
    w_exec_cnt_nxt  = r_exec_cnt;
    w_halt_hold_nxt = r_halt_hold;
    case (r_state)
      IDLE: begin
        if (LD_REQ) begin
          w_state_nxt = LOAD;
        end else if (w_step_edge) begin
          w_state_nxt     = FETCH;
          w_halt_hold_nxt = 1'b0;
        end else if (RUN && !r_halt_hold) begin
          w_state_nxt = FETCH;
        end else if (!RUN) begin
          w_halt_hold_nxt = 1'b0;
        end
      end
      FETCH: begin
        w_state_nxt    = EXEC;
        w_exec_cnt_nxt = EXEC_CNT_INIT;
      end
      EXEC: begin
        // HALT_REQ / LD_REQ are only looked at in the commit cycle.
        if (r_exec_cnt != 2'd0) begin
          w_exec_cnt_nxt = r_exec_cnt - 2'd1;
        end else if (HALT_REQ) begin
          w_state_nxt     = IDLE;
          w_halt_hold_nxt = 1'b1;
        end else if (LD_REQ || !RUN) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = FETCH;
        end
      end
      LOAD: begin
        if (!LD_REQ) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign FETCH_EN    = (r_state == FETCH);
  assign EXEC_EN     = w_exec_en;
  assign LD_GNT      = w_in_load;
  assign HALTED      = (r_state == IDLE);
  assign INSTR_COUNT = r_instr_count;
  assign DBG_STATE   = r_state;

  // CPU writes only land in the commit cycle, so an instruction cut short by
  // reset never reaches memory.
  assign MEM_ADDR  = w_in_load ? LD_ADDR  : CPU_ADDR;
  assign MEM_WDATA = w_in_load ? LD_WDATA : CPU_WDATA;
  assign MEM_WE    = w_in_load ? LD_WE    : (CPU_WE & w_exec_en);

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;
  import simplex8_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int EC = 2;
  localparam int VW = 5 + AW + DW + 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET, RUN, STEP, HALT_REQ, LD_REQ, LD_WE, CPU_WE;
  logic [AW-1:0] LD_ADDR, CPU_ADDR, MEM_ADDR;
  logic [DW-1:0] LD_WDATA, CPU_WDATA, MEM_WDATA;
  logic          LD_GNT, MEM_WE, FETCH_EN, EXEC_EN, HALTED;
  logic [15:0]   INSTR_COUNT;
  state_t        DBG_STATE;

  run_controller #(.ADDR_W(AW), .DATA_W(DW), .EXEC_CYCLES(EC)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .HALT_REQ(HALT_REQ),
    .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA), .LD_WE(LD_WE),
    .LD_GNT(LD_GNT), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_WE(CPU_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WE(MEM_WE), .FETCH_EN(FETCH_EN), .EXEC_EN(EXEC_EN),
    .HALTED(HALTED), .INSTR_COUNT(INSTR_COUNT), .DBG_STATE(DBG_STATE)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = halted, 1 = running an instruction,
  // 2 = loader owns the bus. m_pos is the cycle index inside the
  // instruction (0 = fetch, EC = commit cycle).
  int          m_mode;
  int          m_pos;
  logic [15:0] m_count;
  logic        m_step_prev;
  logic        m_hold;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_count = 16'd0; m_step_prev = 1'b0; m_hold = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // One clock cycle: inputs are already driven; predict this cycle's outputs,
  // queue them, advance the model across the coming posedge, wait for negedge.
  task automatic cycle();
    logic f, e, g, h, we, stp_edge;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!RESET) model_reset();
    f = (m_mode == 1) && (m_pos == 0);
    e = (m_mode == 1) && (m_pos == EC);
    g = (m_mode == 2);
    h = (m_mode == 0);
    if (g) begin a = LD_ADDR;  d = LD_WDATA;  we = LD_WE; end
    else   begin a = CPU_ADDR; d = CPU_WDATA; we = CPU_WE && e; end
    exp_q.push_back({f, e, g, h, we, a, d, m_count});
    if (RESET) begin
      stp_edge    = STEP && !m_step_prev;
      m_step_prev = STEP;
      case (m_mode)
        0: begin
          if (LD_REQ) m_mode = 2;
          else if (stp_edge || (RUN && !m_hold)) begin
            m_mode = 1; m_pos = 0; m_hold = 1'b0;
          end else if (!RUN) m_hold = 1'b0;
        end
        1: begin
          if (m_pos < EC) m_pos++;
          else begin
            m_count = m_count + 16'd1;
            if (HALT_REQ) begin m_mode = 0; m_hold = 1'b1; end
            else if (LD_REQ || !RUN) m_mode = 0;
            else m_pos = 0;
          end
        end
        default: if (!LD_REQ) m_mode = 0;
      endcase
    end
    @(negedge CLK);
  endtask

  task automatic wait_model(input int mode, input int pos, input string name);
    for (int i = 0; i < 20 && !(m_mode == mode && (mode != 1 || m_pos == pos)); i++) cycle();
    check_val(name, 32'(m_mode == mode && (mode != 1 || m_pos == pos)), 32'd1);
  endtask

  // Monitor: compares DUT outputs against queued predictions.
  logic [VW-1:0] exp_v, act_v;
  always @(negedge CLK) begin
    #3;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {FETCH_EN, EXEC_EN, LD_GNT, HALTED, MEM_WE, MEM_ADDR, MEM_WDATA, INSTR_COUNT};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got fetch/exec/gnt/halted/we=%b addr=%h wdata=%h cnt=%h, required %b %h %h %h",
                 $time, act_v[VW-1 -: 5], act_v[AW+DW+15 -: AW], act_v[DW+15 -: DW], act_v[15:0],
                 exp_v[VW-1 -: 5], exp_v[AW+DW+15 -: AW], exp_v[DW+15 -: DW], exp_v[15:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b0; RUN = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0;
    LD_REQ = 1'b0; LD_ADDR = '0; LD_WDATA = '0; LD_WE = 1'b0;
    CPU_ADDR = '0; CPU_WDATA = '0; CPU_WE = 1'b0;
    model_reset();
    @(negedge CLK);
    repeat (3) cycle();

    // Free-run for 30 cycles from reset release.
    RESET = 1'b1; RUN = 1'b1;
    repeat (30) begin
      CPU_ADDR = AW'($urandom); CPU_WDATA = DW'($urandom); CPU_WE = 1'($urandom_range(0, 1));
      cycle();
    end
    #1 check_val("freerun_count", 32'(INSTR_COUNT), 32'd9);

    // Single step with STEP held high, fresh from reset.
    RUN = 1'b0; RESET = 1'b0; cycle();
    RESET = 1'b1; STEP = 1'b1;
    repeat (10) cycle();
    STEP = 1'b0;
    repeat (2) cycle();
    #1 check_val("step_count", 32'(INSTR_COUNT), 32'd1);
    check_val("step_halted", 32'(HALTED), 32'd1);

    // Loader request raised in the first EXEC cycle.
    RUN = 1'b1;
    wait_model(1, 1, "wait_exec1_for_load");
    LD_REQ = 1'b1; LD_WE = 1'b1; LD_ADDR = 16'h0042; LD_WDATA = 8'hA5; CPU_WE = 1'b1;
    repeat (6) cycle();
    #1 check_val("load_gnt", 32'(LD_GNT), 32'd1);
    check_val("load_addr", 32'(MEM_ADDR), 32'h42);
    check_val("load_wdata", 32'(MEM_WDATA), 32'hA5);
    check_val("load_we", 32'(MEM_WE), 32'd1);
    LD_REQ = 1'b0; LD_WE = 1'b0;
    repeat (4) cycle();

    // HALT in the commit cycle with RUN held.
    wait_model(1, EC, "wait_commit_for_halt");
    HALT_REQ = 1'b1; cycle();
    HALT_REQ = 1'b0;
    repeat (8) cycle();
    #1 check_val("halt_stays_idle", 32'(HALTED), 32'd1);
    STEP = 1'b1; cycle();
    STEP = 1'b0;
    repeat (5) cycle();

    // Reset in the commit cycle with a CPU write pending.
    wait_model(1, EC, "wait_commit_for_reset");
    CPU_WE = 1'b1; RESET = 1'b0;
    cycle();
    #1 check_val("reset_count", 32'(INSTR_COUNT), 32'd0);
    check_val("reset_mem_we", 32'(MEM_WE), 32'd0);
    RESET = 1'b1; RUN = 1'b0;
    repeat (2) cycle();

    // Counter wrap from 0xFFFF.
    wait_model(0, 0, "wait_idle_for_wrap");
    #1 force dut.r_instr_count = 16'hFFFF;
    #1 release dut.r_instr_count;
    m_count = 16'hFFFF;
    STEP = 1'b1;
    repeat (5) cycle();
    STEP = 1'b0;
    #1 check_val("wrap_count", 32'(INSTR_COUNT), 32'd0);

    // Randomized traffic.
    repeat (500) begin
      RUN      = ($urandom_range(0, 9) < 7);
      STEP     = ($urandom_range(0, 3) == 0);
      HALT_REQ = ($urandom_range(0, 11) == 0);
      if (LD_REQ) LD_REQ = ($urandom_range(0, 3) != 0);
      else        LD_REQ = ($urandom_range(0, 19) == 0);
      LD_ADDR  = AW'($urandom); LD_WDATA  = DW'($urandom); LD_WE  = 1'($urandom_range(0, 1));
      CPU_ADDR = AW'($urandom); CPU_WDATA = DW'($urandom); CPU_WE = 1'($urandom_range(0, 1));
      RESET    = ($urandom_range(0, 99) != 0);
      cycle();
    end

    RESET = 1'b1;
    #20;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
